// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag controller.
// Owns a single-port tag SRAM (valid bit + tag per set), sweeps it clear after
// reset or flush, and serves one lookup or fill request at a time through
// valid/ready handshakes on the request and response sides.
module icache_tag_ctrl #(
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [INDEX_WIDTH-1:0] req_index,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic [TAG_WIDTH-1:0]   resp_tag,
    output logic                   resp_write,
    input  logic                   flush,
    output logic                   busy,
    output logic                   sram_csb0,
    output logic                   sram_web0,
    output logic [INDEX_WIDTH-1:0] sram_addr0,
    output logic [TAG_WIDTH:0]     sram_din0,
    input  logic [TAG_WIDTH:0]     sram_dout0
);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};

    logic [1:0]             state;
    logic [INDEX_WIDTH-1:0] cnt;
    logic                   flush_pend;
    logic [TAG_WIDTH-1:0]   cap_tag;
    logic                   accept;
    logic                   rd_hit;

    // Handshake and status flags; reset masks them so the rst cycle looks idle-busy.
    always_comb begin
        busy      = rst || (state == S_INIT);
        // Flush in IDLE wins over a simultaneous request, so it blocks ready.
        req_ready = !rst && (state == S_IDLE) && !flush;
        accept    = req_valid && req_ready;
        rd_hit    = sram_dout0[TAG_WIDTH] && (sram_dout0[TAG_WIDTH-1:0] == cap_tag);
    end

    // SRAM port: sweep writes in INIT, one access on the accept cycle, idle otherwise.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path leaves
        // one unassigned, which would otherwise infer a latch.
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = '0;
        sram_din0  = '0;
        if (!rst) begin
            if (state == S_INIT) begin
                sram_csb0  = 1'b0;
                sram_web0  = 1'b0;
                sram_addr0 = cnt;
            end else if (accept) begin
                sram_csb0  = 1'b0;
                sram_web0  = !req_write;
                sram_addr0 = req_index;
                sram_din0  = req_write ? {1'b1, req_tag} : '0;
            end
        end
    end

    // Controller state, sweep counter, deferred flush and registered response.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (rst) begin
            state      <= S_INIT;
            cnt        <= '0;
            flush_pend <= 1'b0;
            cap_tag    <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_tag   <= '0;
            resp_write <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    // A flush here is ignored: the sweep already clears everything.
                    if (cnt == LAST_INDEX) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + INDEX_WIDTH'(1);
                    end
                end
                S_IDLE: begin
                    if (flush) begin
                        state <= S_INIT;
                    end else if (accept) begin
                        resp_write <= req_write;
                        if (req_write) begin
                            // Fill completes at once: echo the written tag.
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_tag   <= req_tag;
                        end else begin
                            state   <= S_RD_WAIT;
                            cap_tag <= req_tag;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Read data is only meaningful in this cycle.
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_hit   <= rd_hit;
                    resp_tag   <= sram_dout0[TAG_WIDTH-1:0];
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        flush_pend <= 1'b0;
                        state      <= (flush_pend || flush) ? S_INIT : S_IDLE;
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a behavioural single-port tag SRAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_icache_tag_ctrl;

    localparam int IW = 4;
    localparam int TW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [IW-1:0] req_index;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_hit;
    logic [TW-1:0] resp_tag;
    logic          resp_write;
    logic          flush;
    logic          busy;
    logic          sram_csb0;
    logic          sram_web0;
    logic [IW-1:0] sram_addr0;
    logic [TW:0]   sram_din0;
    logic [TW:0]   sram_dout0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    icache_tag_ctrl #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_tag   (resp_tag),
        .resp_write (resp_write),
        .flush      (flush),
        .busy       (busy),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    // Single-port SRAM model: read data appears the cycle after the read, X otherwise.
    logic [TW:0] mem [16];
    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0) begin
            mem[sram_addr0] <= sram_din0;
            sram_dout0      <= 'x;
        end else if (!sram_csb0) begin
            sram_dout0 <= mem[sram_addr0];
        end else begin
            sram_dout0 <= 'x;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sixteen zero-writes at addresses 0..15, then IDLE with ready; optional flush pulse mid-sweep.
    task automatic run_sweep(input string name, input int flush_at);
        for (int i = 0; i < 16; i++) begin
            if (i == flush_at) flush = 1'b1;
            @(negedge clk);
            vectors++;
            if ({sram_csb0, sram_web0, sram_addr0, sram_din0, busy, req_ready, resp_valid}
                !== {1'b0, 1'b0, IW'(i), 24'h0, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL %s sweep[%0d]: csb=%b web=%b addr=%0d din=%h busy=%b rdy=%b rv=%b, want 0 0 %0d 000000 1 0 0",
                         name, i, sram_csb0, sram_web0, sram_addr0, sram_din0, busy, req_ready, resp_valid, i);
            end
            tick;
            flush = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if ({busy, req_ready, sram_csb0} !== 3'b011) begin
            miscompares++;
            $display("FAIL %s sweep_done: busy=%b rdy=%b csb=%b, want 0 1 1", name, busy, req_ready, sram_csb0);
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_index = '0; req_tag = '0; resp_ready = 1'b0;
        tick;
        @(negedge clk);
        vectors++;
        if ({sram_csb0, sram_web0, sram_addr0, sram_din0, busy, req_ready, resp_valid, resp_hit, resp_tag, resp_write}
            !== {1'b1, 1'b1, 4'h0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_cycle: csb=%b web=%b addr=%0d din=%h busy=%b rdy=%b rv=%b hit=%b tag=%h rw=%b, want 1 1 0 0 1 0 0 0 0 0",
                     sram_csb0, sram_web0, sram_addr0, sram_din0, busy, req_ready, resp_valid, resp_hit, resp_tag, resp_write);
        end
        tick;
        rst = 1'b0;
        run_sweep("reset", -1);
    endtask

    task automatic test_fill(input string name, input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        logic [TW:0] exp_din;
        exp_din   = {1'b1, tag};
        req_valid = 1'b1; req_write = 1'b1; req_index = idx; req_tag = tag;
        @(negedge clk);
        vectors++;
        if ({req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b1, 1'b0, 1'b0, idx, exp_din}) begin
            miscompares++;
            $display("FAIL %s accept: rdy=%b csb=%b web=%b addr=%0d din=%h, want 1 0 0 %0d %h",
                     name, req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0, idx, exp_din);
        end
        tick;
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_hit, resp_tag, resp_write, req_ready, sram_csb0} !== {1'b1, 1'b0, tag, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL %s resp: rv=%b hit=%b tag=%h rw=%b rdy=%b csb=%b, want 1 0 %h 1 0 1",
                     name, resp_valid, resp_hit, resp_tag, resp_write, req_ready, sram_csb0, tag);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s after_hs: rv=%b rdy=%b, want 0 1", name, resp_valid, req_ready);
        end
        tick;
    endtask

    task automatic do_lookup(input string name, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                             input logic exp_hit, input logic [TW-1:0] exp_tag, input int stall);
        req_valid = 1'b1; req_write = 1'b0; req_index = idx; req_tag = tag;
        @(negedge clk);
        vectors++;
        if ({req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b1, 1'b0, 1'b1, idx, 24'h0}) begin
            miscompares++;
            $display("FAIL %s accept: rdy=%b csb=%b web=%b addr=%0d din=%h, want 1 0 1 %0d 000000",
                     name, req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0, idx);
        end
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({resp_valid, req_ready, sram_csb0} !== 3'b001) begin
            miscompares++;
            $display("FAIL %s rd_wait: rv=%b rdy=%b csb=%b, want 0 0 1", name, resp_valid, req_ready, sram_csb0);
        end
        tick;
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_hit, resp_tag, resp_write} !== {1'b1, exp_hit, exp_tag, 1'b0}) begin
            miscompares++;
            $display("FAIL %s resp: rv=%b hit=%b tag=%h rw=%b, want 1 %b %h 0",
                     name, resp_valid, resp_hit, resp_tag, resp_write, exp_hit, exp_tag);
        end
        // A competing request during back-pressure must not be accepted.
        req_valid = (stall > 0);
        req_index = idx + IW'(1);
        for (int s = 0; s < stall; s++) begin
            tick;
            @(negedge clk);
            vectors++;
            if ({resp_valid, resp_hit, resp_tag, resp_write, req_ready, sram_csb0}
                !== {1'b1, exp_hit, exp_tag, 1'b0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL %s stall[%0d]: rv=%b hit=%b tag=%h rw=%b rdy=%b csb=%b, want 1 %b %h 0 0 1",
                         name, s, resp_valid, resp_hit, resp_tag, resp_write, req_ready, sram_csb0, exp_hit, exp_tag);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s after_hs: rv=%b rdy=%b, want 0 1", name, resp_valid, req_ready);
        end
        tick;
    endtask

    task automatic test_fill_and_hit;
        test_fill("fill5", 4'd5, 23'h012345);
        do_lookup("hit5", 4'd5, 23'h012345, 1'b1, 23'h012345, 0);
    endtask

    task automatic test_miss;
        do_lookup("miss_tag", 4'd5, 23'h012346, 1'b0, 23'h012345, 0);
        do_lookup("miss_idx", 4'd6, 23'h012345, 1'b0, 23'h000000, 0);
    endtask

    task automatic test_backpressure;
        do_lookup("stall", 4'd5, 23'h012345, 1'b1, 23'h012345, 3);
    endtask

    task automatic test_back_to_back;
        test_fill("fill15_max", 4'd15, 23'h7FFFFF);
        do_lookup("hit15_max", 4'd15, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 0);
        do_lookup("hit5_again", 4'd5, 23'h012345, 1'b1, 23'h012345, 0);
    endtask

    task automatic test_flush_rd_wait;
        req_valid = 1'b1; req_write = 1'b0; req_index = 4'd5; req_tag = 23'h012345;
        tick;
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        vectors++;
        if ({resp_valid, busy, req_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_rd_wait wait: rv=%b busy=%b rdy=%b, want 0 0 0", resp_valid, busy, req_ready);
        end
        tick;
        flush = 1'b0;
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_hit, resp_tag, busy, req_ready} !== {1'b1, 1'b1, 23'h012345, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_rd_wait resp: rv=%b hit=%b tag=%h busy=%b rdy=%b, want 1 1 012345 0 0",
                     resp_valid, resp_hit, resp_tag, busy, req_ready);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        run_sweep("flush_rd_wait", -1);
        do_lookup("post_flush", 4'd5, 23'h012345, 1'b0, 23'h000000, 0);
    endtask

    task automatic test_flush_idle;
        test_fill("fill3", 4'd3, 23'h000001);
        flush = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_index = 4'd7; req_tag = 23'h0000AA;
        @(negedge clk);
        vectors++;
        if ({req_ready, sram_csb0, sram_web0, busy} !== 4'b0110) begin
            miscompares++;
            $display("FAIL flush_idle: rdy=%b csb=%b web=%b busy=%b, want 0 1 1 0", req_ready, sram_csb0, sram_web0, busy);
        end
        tick;
        flush = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        run_sweep("flush_idle", 4);
        do_lookup("flush_idle_3", 4'd3, 23'h000001, 1'b0, 23'h000000, 0);
        do_lookup("flush_idle_7", 4'd7, 23'h0000AA, 1'b0, 23'h000000, 0);
    endtask

    task automatic test_rst_rd_wait;
        test_fill("fill9", 4'd9, 23'h00BEEF);
        req_valid = 1'b1; req_write = 1'b0; req_index = 4'd9; req_tag = 23'h00BEEF;
        tick;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        vectors++;
        if ({sram_csb0, sram_web0, sram_addr0, sram_din0, busy, req_ready}
            !== {1'b1, 1'b1, 4'h0, 24'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_rd_wait cycle: csb=%b web=%b addr=%0d din=%h busy=%b rdy=%b, want 1 1 0 0 1 0",
                     sram_csb0, sram_web0, sram_addr0, sram_din0, busy, req_ready);
        end
        tick;
        rst = 1'b0;
        run_sweep("rst_rd_wait", -1);
        do_lookup("post_rst", 4'd9, 23'h00BEEF, 1'b0, 23'h000000, 0);
    endtask

    initial begin
        test_reset;
        test_fill_and_hit;
        test_miss;
        test_backpressure;
        test_back_to_back;
        test_flush_rd_wait;
        test_flush_idle;
        test_rst_rd_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
